// File: rtl/sevenseg_scan_ctrl_if.sv
// Display-byte write port for the two-digit 7-segment scan controller.
// The producer holds wr_data_i until wr_valid_i && wr_ready_o.
interface sevenseg_scan_ctrl_if;
  logic       wr_valid_i;
  logic       wr_ready_o;
  logic [7:0] wr_data_i;

  modport master (
    output wr_valid_i,
    output wr_data_i,
    input  wr_ready_o
  );

  modport slave (
    input  wr_valid_i,
    input  wr_data_i,
    output wr_ready_o
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Two-digit common-anode 7-segment scan controller with blanking guard.
// A new byte is shown only from the next frame start (tear-free).
module sevenseg_scan_ctrl #(
  parameter int SysClkFreq  = 50_000_000,
  parameter int DigitHz     = 1000,
  parameter int BlankCycles = 500
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_i,
  input  logic                 en_i,
  sevenseg_scan_ctrl_if.slave  wr,
  output logic [6:0]           seg_on_o,
  output logic                 ca_sel_o,
  output logic                 frame_o
);

  localparam int DigitCycles = SysClkFreq / DigitHz;
  localparam int ShowCycles  = DigitCycles - BlankCycles;
  localparam int CntW        = $clog2(DigitCycles);

  localparam logic [CntW-1:0] BlankLd = CntW'(BlankCycles - 1);
  localparam logic [CntW-1:0] ShowLd  = CntW'(ShowCycles - 1);

  if (BlankCycles < 1 || BlankCycles >= DigitCycles) begin : g_bad_blank
    $error("BlankCycles must satisfy 1 <= BlankCycles < DigitCycles");
  end

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BLANK0 = 3'd1;
  localparam logic [2:0] SHOW0  = 3'd2;
  localparam logic [2:0] BLANK1 = 3'd3;
  localparam logic [2:0] SHOW1  = 3'd4;

  logic [2:0]      state_q;
  logic [2:0]      state_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic [7:0]      disp_q;
  logic [7:0]      pend_data_q;
  logic            pending_q;
  logic [6:0]      seg_q;
  logic [6:0]      seg_d;
  logic            ca_q;
  logic            ca_d;
  logic            frame_q;
  logic            frame_d;
  logic            load;
  logic            accept;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign accept        = wr.wr_valid_i && !pending_q;
  assign wr.wr_ready_o = !pending_q;

  assign seg_on_o = seg_q;
  assign ca_sel_o = ca_q;
  assign frame_o  = frame_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    ca_d    = ca_q;
    frame_d = 1'b0;
    load    = 1'b0;
    if (state_q == IDLE) begin
      load  = 1'b1;
      seg_d = 7'h00;
      ca_d  = 1'b0;
      cnt_d = '0;
      if (en_i) begin
        state_d = BLANK0;
        cnt_d   = BlankLd;
        frame_d = 1'b1;
      end
    end else if (!en_i) begin
      // Leaving mid-dwell: discard the partial count.
      state_d = IDLE;
      cnt_d   = '0;
      seg_d   = 7'h00;
      ca_d    = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      unique case (state_q)
        BLANK0: begin
          state_d = SHOW0;
          cnt_d   = ShowLd;
          seg_d   = decode(disp_q[3:0]);
        end
        SHOW0: begin
          state_d = BLANK1;
          cnt_d   = BlankLd;
          seg_d   = 7'h00;
          ca_d    = 1'b1;
        end
        BLANK1: begin
          state_d = SHOW1;
          cnt_d   = ShowLd;
          seg_d   = decode(disp_q[7:4]);
        end
        SHOW1: begin
          state_d = BLANK0;
          cnt_d   = BlankLd;
          seg_d   = 7'h00;
          ca_d    = 1'b0;
          frame_d = 1'b1;
          load    = 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          seg_d   = 7'h00;
          ca_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      disp_q      <= 8'h00;
      pend_data_q <= 8'h00;
      pending_q   <= 1'b0;
      seg_q       <= 7'h00;
      ca_q        <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      ca_q    <= ca_d;
      frame_q <= frame_d;
      if (load && pending_q) begin
        disp_q <= pend_data_q;
      end
      // A write on a frame edge lands in the holding register only.
      if (accept) begin
        pend_data_q <= wr.wr_data_i;
        pending_q   <= 1'b1;
      end else if (load) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl against a frame-phase model.
// Small timing parameters: 10-cycle digit dwell, 2 blank cycles.
module tb_sevenseg_scan_ctrl;

  localparam int Blank = 2;
  localparam int Digit = 10;
  localparam int Frame = 2 * Digit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [6:0] seg;
  logic       ca;
  logic       frame;

  int total = 0;
  int bad   = 0;

  sevenseg_scan_ctrl_if wr_if ();

  sevenseg_scan_ctrl #(
    .SysClkFreq (1000),
    .DigitHz    (100),
    .BlankCycles(Blank)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_i(rst),
    .en_i     (en),
    .wr       (wr_if),
    .seg_on_o (seg),
    .ca_sel_o (ca),
    .frame_o  (frame)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model: scanning flag, cycles since frame start, shown/pending bytes.
  bit         m_scan = 0;
  int         m_t    = 0;
  logic [7:0] m_disp  = 8'h00;
  logic [7:0] m_pdata = 8'h00;
  bit         m_pend = 0;
  bit         m_acc  = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg();
    if (!m_scan || m_t < Blank) return 7'h00;
    if (m_t >= Digit && m_t < Digit + Blank) return 7'h00;
    if (m_t < Digit) return hex_tbl[m_disp[3:0]];
    return hex_tbl[m_disp[7:4]];
  endfunction

  task automatic model_edge();
    bit load;
    bit acc;
    load  = 0;
    acc   = wr_if.wr_valid_i && !m_pend;
    m_acc = 0;
    if (rst) begin
      m_scan  = 0;
      m_t     = 0;
      m_disp  = 8'h00;
      m_pdata = 8'h00;
      m_pend  = 0;
    end else begin
      if (!m_scan) begin
        load = 1;
        if (en) begin
          m_scan = 1;
          m_t    = 0;
        end
      end else if (!en) begin
        m_scan = 0;
      end else begin
        m_t++;
        if (m_t == Frame) begin
          m_t  = 0;
          load = 1;
        end
      end
      if (load && m_pend) m_disp = m_pdata;
      if (load) m_pend = 0;
      if (acc) begin
        m_pdata = wr_if.wr_data_i;
        m_pend  = 1;
      end
      m_acc = acc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("seg", {1'b0, seg}, {1'b0, exp_seg()});
    chk("ca", {7'b0, ca}, {7'b0, m_scan && m_t >= Digit});
    chk("frame", {7'b0, frame}, {7'b0, m_scan && m_t == 0});
    chk("ready", {7'b0, wr_if.wr_ready_o}, {7'b0, !m_pend});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (!(m_scan && m_t == p) && n < 100) begin
      step();
      n++;
    end
    chk("wait_phase", {7'b0, m_scan && m_t == p}, 8'h01);
  endtask

  task automatic write_byte(input logic [7:0] d);
    int n;
    n = 0;
    wr_if.wr_valid_i = 1'b1;
    wr_if.wr_data_i  = d;
    do begin
      step();
      n++;
    end while (!m_acc && n < 100);
    wr_if.wr_valid_i = 1'b0;
    chk("accept", {7'b0, m_acc}, 8'h01);
  endtask

  initial begin
    wr_if.wr_valid_i = 1'b0;
    wr_if.wr_data_i  = 8'h00;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(3);

    write_byte(8'h3A);
    step();
    chk("disp_idle_load", dut.disp_q, 8'h3A);
    chk("disp_model", dut.disp_q, m_disp);

    en = 1'b1;
    run(2 * Frame + 5);

    wait_phase(5);
    write_byte(8'h81);
    run(2 * Frame);

    wait_phase(4);
    write_byte(8'h55);
    write_byte(8'h66);
    run(3 * Frame);

    wait_phase(15);
    en = 1'b0;
    step();
    run(3);
    en = 1'b1;
    run(Frame + 5);

    for (int i = 0; i < 400; i++) begin
      if (!wr_if.wr_valid_i && $urandom_range(7) == 0) begin
        wr_if.wr_valid_i = 1'b1;
        wr_if.wr_data_i  = 8'($urandom);
      end
      if ($urandom_range(60) == 0) en = !en;
      step();
      if (m_acc) wr_if.wr_valid_i = 1'b0;
    end
    wr_if.wr_valid_i = 1'b0;
    en = 1'b1;

    wait_phase(3);
    write_byte(8'hC4);
    chk("pending_set", {7'b0, dut.pending_q}, {7'b0, m_pend});
    rst = 1'b1;
    step();
    chk("rst_pending", {7'b0, dut.pending_q}, 8'h00);
    chk("rst_disp", dut.disp_q, m_disp);
    rst = 1'b0;
    en  = 1'b0;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
